quad_enc_gen: RTL and testbench

- Quadrature encoder signal generator: the transmit end of the enc_a/enc_b interface consumed by the encoder/PWM block.
- Takes a signed step command and an edge period, then emits the A/B quadrature sequence one edge per period.
- Keeps a running position count.
- Used for loopback test of the encoder inputs and as an encoder emulator on the chip.

---
 rtl/quad_enc_pkg.sv | 30 +++
 rtl/quad_step_timer.sv | 35 +++
 rtl/quad_enc_gen.sv | 145 ++++++++++++++
 tb/tb_quad_enc_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder generator: FSM encoding,
// direction constants and the phase-to-(A,B) Gray lookup.
package quad_enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // {A,B} per phase; stepping the phase up walks the forward (A leads B) order.
  localparam logic [1:0] AB_PH0 = 2'b00;
  localparam logic [1:0] AB_PH1 = 2'b10;
  localparam logic [1:0] AB_PH2 = 2'b11;
  localparam logic [1:0] AB_PH3 = 2'b01;

  function automatic logic [1:0] phase_ab(input logic [1:0] ph);
    logic [1:0] ab;
    case (ph)
      2'd0:    ab = AB_PH0;
      2'd1:    ab = AB_PH1;
      2'd2:    ab = AB_PH2;
      default: ab = AB_PH3;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Edge-period down-counter: tick is high while the count sits at zero; an
// enabled tick reloads the count, so ticks recur every reload_val+1 cycles.
module quad_step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = reload_val;
    end else if (en) begin
      cnt_d = tick ? reload_val : (cnt_q - DIV_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: runs a signed step command as a Gray A/B
// sequence, one edge per programmed period, tracking a wrapping position.
module quad_enc_gen
  import quad_enc_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position,
  output state_t           dbg_state
);

  // Command handshake: a command is taken on a clock edge where
  // cmd_valid && cmd_ready; cmd_ready is high exactly while IDLE, and
  // cmd_valid in RUN is simply not taken (no queueing).

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0] per_m1_q, per_m1_d;
  logic             enc_a_q, enc_a_d;
  logic             enc_b_q, enc_b_d;
  logic [CNT_W-1:0] position_q, position_d;
  logic             done_q, done_d;

  logic             timer_load;
  logic             timer_en;
  logic [DIV_W-1:0] timer_reload;
  logic             timer_tick;

  logic [CNT_W-1:0] abs_steps;
  logic [DIV_W-1:0] cmd_per_m1;

  // Magnitude as unsigned so the most negative command still yields 2^(CNT_W-1).
  assign abs_steps  = cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
  assign cmd_per_m1 = (cmd_period == '0) ? '0 : (cmd_period - DIV_W'(1));

  quad_step_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .en        (timer_en),
    .reload_val(timer_reload),
    .tick      (timer_tick)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dir_d        = dir_q;
    remaining_d  = remaining_q;
    per_m1_d     = per_m1_q;
    enc_a_d      = enc_a_q;
    enc_b_d      = enc_b_q;
    position_d   = position_q;
    done_d       = 1'b0;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    timer_reload = per_m1_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d  = abs_steps;
            dir_d        = cmd_steps[CNT_W-1];
            per_m1_d     = cmd_per_m1;
            timer_load   = 1'b1;
            timer_reload = cmd_per_m1;
            state_d      = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a step falling due in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          timer_en = 1'b1;
          if (timer_tick) begin
            phase_d              = (dir_q == DIR_REV) ? (phase_q - 2'd1) : (phase_q + 2'd1);
            {enc_a_d, enc_b_d}   = phase_ab(phase_d);
            position_d           = (dir_q == DIR_REV) ? (position_q - CNT_W'(1))
                                                      : (position_q + CNT_W'(1));
            remaining_d          = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      dir_q       <= DIR_FWD;
      remaining_q <= '0;
      per_m1_q    <= '0;
      enc_a_q     <= 1'b0;
      enc_b_q     <= 1'b0;
      position_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      per_m1_q    <= per_m1_d;
      enc_a_q     <= enc_a_d;
      enc_b_q     <= enc_b_d;
      position_q  <= position_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;
  assign done      = done_q;
  assign position  = position_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen: per-scenario tasks with hand-derived
// expectations for the A/B sequence, position, busy and done.
module tb_quad_enc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic        enc_a;
  logic        enc_b;
  logic        busy;
  logic        done;
  logic [15:0] position;
  quad_enc_pkg::state_t dbg_state;

  int total = 0;
  int bad   = 0;

  quad_enc_gen #(.CNT_W(16), .DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .busy      (busy),
    .done      (done),
    .position  (position),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  // Presents a command for one edge; returns 1 ns after that accept edge.
  task automatic send_cmd(input logic [15:0] s, input logic [15:0] p);
    cmd_steps  = s;
    cmd_period = p;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Forward Gray order 00,10,11,01 indexed by step count.
  function automatic logic [1:0] ab_fwd(input int n);
    logic [1:0] ab;
    case (n & 3)
      0:       ab = 2'b00;
      1:       ab = 2'b10;
      2:       ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  // ---- scenarios ----
  task automatic test_reset();
    cmd_valid = 1'b0; abort = 1'b0; cmd_steps = '0; cmd_period = '0;
    reset = 1'b0;
    tick();
    total++; if ({enc_a, enc_b} !== 2'b00) begin bad++; $display("FAIL reset_ab: got %b want 00", {enc_a, enc_b}); end
    total++; if (position !== 16'h0000) begin bad++; $display("FAIL reset_pos: got %h want 0000", position); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    total++; if (dbg_state !== quad_enc_pkg::ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fwd_period3();
    int n;
    logic [1:0] exp_ab;
    logic exp_done, exp_busy;
    apply_reset();
    send_cmd(16'd4, 16'd3);
    total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL fwd3_accept: busy=%b ready=%b want 1/0", busy, cmd_ready); end
    for (int k = 1; k <= 13; k++) begin
      tick();
      n = (k / 3 > 4) ? 4 : k / 3;
      exp_ab   = ab_fwd(n);
      exp_done = (k == 12);
      exp_busy = (k < 12);
      total++; if ({enc_a, enc_b} !== exp_ab) begin bad++; $display("FAIL fwd3_ab@%0d: got %b want %b", k, {enc_a, enc_b}, exp_ab); end
      total++; if (done !== exp_done) begin bad++; $display("FAIL fwd3_done@%0d: got %b want %b", k, done, exp_done); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL fwd3_busy@%0d: got %b want %b", k, busy, exp_busy); end
    end
    total++; if (position !== 16'd4) begin bad++; $display("FAIL fwd3_pos: got %h want 0004", position); end
  endtask

  task automatic test_rev_period1();
    int n;
    logic [1:0] exp_ab;
    logic exp_done;
    apply_reset();
    send_cmd(16'hFFFD, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n = (k > 3) ? 3 : k;
      exp_ab   = ab_fwd(4 - n);
      exp_done = (k == 3);
      total++; if ({enc_a, enc_b} !== exp_ab) begin bad++; $display("FAIL rev1_ab@%0d: got %b want %b", k, {enc_a, enc_b}, exp_ab); end
      total++; if (done !== exp_done) begin bad++; $display("FAIL rev1_done@%0d: got %b want %b", k, done, exp_done); end
    end
    total++; if (position !== 16'hFFFD) begin bad++; $display("FAIL rev1_pos: got %h want fffd", position); end
  endtask

  task automatic test_period_zero();
    int n;
    logic [1:0] exp_ab;
    logic exp_done;
    apply_reset();
    send_cmd(16'd2, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n = (k > 2) ? 2 : k;
      exp_ab   = ab_fwd(n);
      exp_done = (k == 2);
      total++; if ({enc_a, enc_b} !== exp_ab) begin bad++; $display("FAIL per0_ab@%0d: got %b want %b", k, {enc_a, enc_b}, exp_ab); end
      total++; if (done !== exp_done) begin bad++; $display("FAIL per0_done@%0d: got %b want %b", k, done, exp_done); end
    end
    total++; if (position !== 16'd2) begin bad++; $display("FAIL per0_pos: got %h want 0002", position); end
  endtask

  // Zero-step command presented in the cycle right after a done pulse.
  task automatic test_zero_back_to_back();
    apply_reset();
    send_cmd(16'd1, 16'd1);
    tick();
    total++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_done: done=%b ready=%b want 1/1", done, cmd_ready); end
    send_cmd(16'd0, 16'd5);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_busy: busy=%b ready=%b want 0/1", busy, cmd_ready); end
    total++; if ({enc_a, enc_b} !== 2'b10) begin bad++; $display("FAIL zero_ab: got %b want 10", {enc_a, enc_b}); end
    total++; if (position !== 16'd1) begin bad++; $display("FAIL zero_pos: got %h want 0001", position); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_clear: got %b want 0", done); end
    send_cmd(16'hFFFF, 16'd1);
    tick();
    total++; if ({enc_a, enc_b} !== 2'b00 || position !== 16'd0) begin bad++; $display("FAIL b2b_rev: ab=%b pos=%h want 00/0000", {enc_a, enc_b}, position); end
  endtask

  // Abort lands on the cycle the third step would have been taken.
  task automatic test_abort();
    apply_reset();
    send_cmd(16'd10, 16'd2);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_busy: busy=%b ready=%b want 0/1", busy, cmd_ready); end
    total++; if ({enc_a, enc_b} !== 2'b11) begin bad++; $display("FAIL abort_ab: got %b want 11", {enc_a, enc_b}); end
    total++; if (position !== 16'd2) begin bad++; $display("FAIL abort_pos: got %h want 0002", position); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
    tick();
    total++; if (done !== 1'b0 || {enc_a, enc_b} !== 2'b11) begin bad++; $display("FAIL abort_hold: done=%b ab=%b want 0/11", done, {enc_a, enc_b}); end
    send_cmd(16'd1, 16'd1);
    tick();
    total++; if ({enc_a, enc_b} !== 2'b01) begin bad++; $display("FAIL abort_next_ab: got %b want 01", {enc_a, enc_b}); end
    total++; if (position !== 16'd3 || done !== 1'b1) begin bad++; $display("FAIL abort_next: pos=%h done=%b want 0003/1", position, done); end
  endtask

  task automatic test_run_ignores_cmd();
    apply_reset();
    send_cmd(16'd2, 16'd4);
    cmd_steps = 16'd5; cmd_period = 16'd1; cmd_valid = 1'b1;
    repeat (7) tick();
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b1 || position !== 16'd1) begin bad++; $display("FAIL ignore_mid: busy=%b pos=%h want 1/0001", busy, position); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL ignore_end: busy=%b done=%b want 0/1", busy, done); end
    total++; if (position !== 16'd2 || {enc_a, enc_b} !== 2'b11) begin bad++; $display("FAIL ignore_pos: pos=%h ab=%b want 0002/11", position, {enc_a, enc_b}); end
  endtask

  task automatic test_min_steps();
    apply_reset();
    send_cmd(16'h8000, 16'd1);
    repeat (32767) tick();
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL min_pre: busy=%b done=%b want 1/0", busy, done); end
    total++; if (position !== 16'h8001) begin bad++; $display("FAIL min_pre_pos: got %h want 8001", position); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL min_end: busy=%b done=%b want 0/1", busy, done); end
    total++; if (position !== 16'h8000 || {enc_a, enc_b} !== 2'b00) begin bad++; $display("FAIL min_pos: pos=%h ab=%b want 8000/00", position, {enc_a, enc_b}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_cmd(16'd5, 16'd2);
    repeat (4) tick();
    total++; if ({enc_a, enc_b} !== 2'b11 || position !== 16'd2) begin bad++; $display("FAIL arst_pre: ab=%b pos=%h want 11/0002", {enc_a, enc_b}, position); end
    #2;
    reset = 1'b0;
    #1;
    total++; if ({enc_a, enc_b} !== 2'b00 || position !== 16'd0) begin bad++; $display("FAIL arst_ab_pos: ab=%b pos=%h want 00/0000", {enc_a, enc_b}, position); end
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL arst_ctrl: busy=%b ready=%b done=%b want 0/1/0", busy, cmd_ready, done); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    send_cmd(16'd1, 16'd1);
    tick();
    total++; if ({enc_a, enc_b} !== 2'b10 || position !== 16'd1) begin bad++; $display("FAIL arst_after: ab=%b pos=%h want 10/0001", {enc_a, enc_b}, position); end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_steps = '0; cmd_period = '0;
    test_reset();
    test_fwd_period3();
    test_rev_period1();
    test_period_zero();
    test_zero_back_to_back();
    test_abort();
    test_run_ignores_cmd();
    test_min_steps();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
